// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: external data-RAM request/ack port.
interface mem_access_ctrl_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_wdata;
  logic              mem_ack;
  logic [63:0]       mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wmask, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: EX->MEM data-memory access controller with lane shifting, stall and timeout.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  mem_access_ctrl_if.master mem,
  output logic [63:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0]        l_wmask;
  logic [63:0]       l_wdata;
  logic              accept, mis, busy, last;
  logic [7:0]        smask;
  assign busy = state == BUSY;
  assign last = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    accept = state == IDLE && req_valid && !flush;
    mis    = (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && |req_addr[1:0]) ||
             (req_size == 2'd3 && |req_addr[2:0]);
    smask  = req_size == 2'd0 ? 8'h01 : req_size == 2'd1 ? 8'h03 : req_size == 2'd2 ? 8'h0F : 8'hFF;
    nxt    = state == IDLE ? (accept ? (mis ? ERR : BUSY) : IDLE)
           : busy ? (mem.mem_ack ? DONE : (last ? ERR : BUSY))
           : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      l_we     <= 1'b0;
      l_addr   <= '0;
      l_wmask  <= '0;
      l_wdata  <= '0;
      rdata    <= '0;
      err_code <= '0;
    end else begin
      state <= nxt;
      cnt   <= busy ? cnt + 1'b1 : '0;
      if (accept && !mis) begin
        l_we    <= req_we;
        l_addr  <= req_addr;
        l_wmask <= req_we ? smask << req_addr[2:0] : 8'h00;
        l_wdata <= req_wdata << {req_addr[2:0], 3'b000};
      end
      if (nxt == ERR) err_code <= busy ? 2'd2 : 2'd1;
      if (busy && mem.mem_ack && !l_we) rdata <= mem.mem_rdata >> {l_addr[2:0], 3'b000};
    end
  end
  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy && l_we;
  assign mem.mem_addr  = busy ? {l_addr[ADDR_W-1:3], 3'b000} : '0;
  assign mem.mem_wmask = busy ? l_wmask : '0;
  assign mem.mem_wdata = busy ? l_wdata : '0;
  assign stall         = accept || busy;
  assign done          = state == DONE;
  assign err           = state == ERR;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random accesses checked against a byte-level reference model.
module tb_mem_access_ctrl;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, req_valid = 1'b0, req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, rdata;
  logic        stall, done, err;
  logic [1:0]  err_code;
  int          vectors = 0, miscompares = 0;
  logic [63:0] exp_rdata = '0;
  logic [1:0]  exp_code = '0;
  mem_access_ctrl_if #(.ADDR_W(32)) bus();
  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .mem(bus),
    .rdata(rdata), .stall(stall), .done(done), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [63:0] rd, input int dly, input logic fl_busy);
    int bytes = 1 << size;
    int off = int'(addr % 8);
    bit mis = (addr % bytes) != 0;
    bit acked = 0;
    logic [7:0]  emask = we ? 8'(((1 << bytes) - 1) << off) : 8'h00;
    logic [63:0] ewd = wd << (8 * off);
    logic [63:0] erd = '0;
    for (int i = 0; i < 8; i++) erd[8*i +: 8] = (off + i < 8) ? rd[8*(off+i) +: 8] : 8'h00;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
    #1;
    chk("accept_stall", stall, 1);
    chk("accept_noreq", bus.mem_req, 0);
    @(negedge clk);
    if (mis) begin
      exp_code = 2'd1;
      chk("mis_err", err, 1);
      chk("mis_code", err_code, exp_code);
      chk("mis_stall", stall, 0);
      chk("mis_noreq", bus.mem_req, 0);
    end else begin
      for (int k = 0; k < TO && !acked; k++) begin
        chk("busy_req", bus.mem_req, 1);
        chk("busy_stall", stall, 1);
        chk("busy_we", bus.mem_we, we);
        chk("busy_addr", bus.mem_addr, addr & ~32'h7);
        chk("busy_wmask", bus.mem_wmask, emask);
        chk("busy_wdata", bus.mem_wdata, ewd);
        flush = fl_busy;
        if (k == dly) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = rd; acked = 1;
        end else bus.mem_rdata = {$urandom, $urandom};
        @(negedge clk);
      end
      bus.mem_ack = 1'b0; flush = 1'b0;
      if (acked) begin
        if (!we) exp_rdata = erd;
        chk("done_pulse", done, 1);
        chk("done_noerr", err, 0);
      end else begin
        exp_code = 2'd2;
        chk("to_err", err, 1);
        chk("to_code", err_code, exp_code);
        chk("to_nodone", done, 0);
      end
      chk("end_stall", stall, 0);
      chk("end_noreq", bus.mem_req, 0);
      chk("rdata", rdata, exp_rdata);
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_req", bus.mem_req, 0);
    chk("idle_stall", stall, 0);
    chk("idle_code", err_code, exp_code);
  endtask
  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    access(0, 2'd3, 32'h80000010, 64'h0, 64'h1122334455667788, 2, 0);
    access(1, 2'd0, 32'h80000005, 64'hAB, 64'h0, 0, 0);
    access(0, 2'd1, 32'h80000006, 64'h0, 64'hBEEF000000000000, 0, 0);
    access(0, 2'd2, 32'h80000002, 64'h0, 64'h0, 0, 0);
    access(0, 2'd2, 32'h80000020, 64'h0, 64'h0, 99, 0);
    access(1, 2'd2, 32'h80000024, 64'hCAFEF00D, 64'h0, 1, 0);
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_addr = 32'h80000040; req_size = 2'd3;
    #1;
    chk("flush_stall", stall, 0);
    @(negedge clk);
    chk("flush_noreq", bus.mem_req, 0);
    req_valid = 1'b0; flush = 1'b0;
    access(0, 2'd3, 32'h80000048, 64'h0, 64'h0123456789ABCDEF, 3, 1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = 32'h80000050; req_wdata = 64'h55;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_req", bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0; exp_code = '0;
    chk("midrst_req", bus.mem_req, 0);
    chk("midrst_wmask", bus.mem_wmask, 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_code", err_code, 0);
    chk("midrst_rdata", rdata, 0);
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [31:0] a = 32'h80000000 | ($urandom & 32'h0000FFF8);
      if ($urandom_range(0, 2) == 0) a = a | 32'($urandom_range(0, 7));
      else a = a | ((32'($urandom_range(0, 7)) >> sz) << sz);
      access(1'($urandom), sz, a, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 5)), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
